tlb_sv39: RTL and testbench

- Fully-associative, ASID-tagged translation cache for 4 KiB pages. Sits directly upstream of the Sv39 page-table walker in the memory stage.
- Serves address translation requests from the LSU/fetch side.
- On a miss, drives the walker's request interface and installs the returned leaf translation.
- Handles bare mode (satp.MODE=0) locally, without walking.

---
 rtl/tlb_pkg.sv | 21 ++
 rtl/tlb_match.sv | 38 +++
 rtl/tlb_sv39.sv | 177 +++++++++++++++++
 tb/tb_tlb_sv39.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_pkg.sv
// Shared types for the Sv39 TLB: satp mode codes, entry layout, FSM states.
package tlb_pkg;

    localparam logic [3:0] SATP_MODE_BARE = 4'd0;
    localparam logic [3:0] SATP_MODE_SV39 = 4'd8;
    localparam int         TLB_ASID_W     = 16;

    typedef struct packed {
        logic                  valid;
        logic [TLB_ASID_W-1:0] asid;
        logic [26:0]           vpn;
        logic [43:0]           ppn;
    } tlb_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WALK,
        RESP
    } state_t;

endpackage

// File: rtl/tlb_match.sv
// NENTRY-way tag comparator with lowest-index priority select.
module tlb_match
    import tlb_pkg::*;
#(
    parameter int NENTRY = 8,
    parameter int IW     = $clog2(NENTRY)
) (
    input  tlb_entry_t            i_ent [NENTRY],
    input  logic [26:0]           i_vpn,
    input  logic [TLB_ASID_W-1:0] i_asid,
    output logic                  o_hit,
    output logic [IW-1:0]         o_hit_idx
);

    logic w_unused;

    // Scan downwards so the lowest matching index is the last one written.
    always_comb begin
        o_hit     = 1'b0;
        o_hit_idx = '0;
        for (int i = NENTRY - 1; i >= 0; i--) begin
            if (i_ent[i].valid &&
                i_ent[i].vpn == i_vpn &&
                i_ent[i].asid == i_asid) begin
                o_hit     = 1'b1;
                o_hit_idx = IW'(i);
            end
        end
    end

    always_comb begin
        w_unused = 1'b0;
        for (int i = 0; i < NENTRY; i++) begin
            w_unused = w_unused ^ (^i_ent[i].ppn);
        end
    end

endmodule

// File: rtl/tlb_sv39.sv
// Fully-associative ASID-tagged Sv39 TLB in front of the page-table walker.
// Define TLB_STATS_EN to add hit_cnt/miss_cnt outputs.
module tlb_sv39
    import tlb_pkg::*;
#(
    parameter int NENTRY = 8,
    parameter int ASID_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [63:0] req_va,
    input  logic [63:0] satp,
    input  logic        flush,
    output logic        resp_valid,
    output logic [63:0] resp_pa,
    output logic        resp_fault,
    output logic        walk_req,
    output logic [63:0] walk_va,
    input  logic        walk_done,
    input  logic        walk_ok,
    input  logic [63:0] walk_pa
`ifdef TLB_STATS_EN
    ,
    output logic [31:0] hit_cnt,
    output logic [31:0] miss_cnt
`endif
);

    localparam int IW = $clog2(NENTRY);

    state_t            r_state;
    state_t            w_next;
    tlb_entry_t        r_tlb [NENTRY];
    logic [IW-1:0]     r_ptr;
    logic [63:0]       r_va;
    logic [ASID_W-1:0] r_asid;
    logic              r_flush_seen;
    logic              r_resp_valid;
    logic [63:0]       r_resp_pa;
    logic              r_resp_fault;

    logic [ASID_W-1:0] w_asid;
    logic [3:0]        w_mode;
    logic              w_accept;
    logic              w_canon;
    logic              w_hit;
    logic [IW-1:0]     w_hit_idx;
    logic              w_bare;
    logic              w_bad;
    logic              w_hit_ok;
    logic              w_miss_ok;
    logic              w_walk_end;
    logic              w_install;
    logic              w_unused;

    assign w_mode   = satp[63:60];
    assign w_asid   = satp[44 +: ASID_W];
    assign w_unused = ^satp[43:0];
    assign w_canon  = (req_va[63:38] == '0) || (req_va[63:38] == '1);

    assign req_ready = (r_state == IDLE) && !flush && !reset;
    assign w_accept  = req_valid && req_ready;

    assign w_bare    = w_mode == SATP_MODE_BARE;
    assign w_bad     = !w_bare && !(w_mode == SATP_MODE_SV39 && w_canon);
    assign w_hit_ok  = w_mode == SATP_MODE_SV39 && w_canon && w_hit;
    assign w_miss_ok = w_mode == SATP_MODE_SV39 && w_canon && !w_hit;

    assign w_walk_end = (r_state == WALK) && walk_done;
    // A flush anywhere in the walk window blocks installing its result.
    assign w_install  = w_walk_end && walk_ok && !r_flush_seen && !flush;

    assign walk_req   = r_state == WALK;
    assign walk_va    = r_va;
    assign resp_valid = r_resp_valid;
    assign resp_pa    = r_resp_pa;
    assign resp_fault = r_resp_fault;

    tlb_match #(
        .NENTRY (NENTRY)
    ) u_match (
        .i_ent     (r_tlb),
        .i_vpn     (req_va[38:12]),
        .i_asid    (TLB_ASID_W'(w_asid)),
        .o_hit     (w_hit),
        .o_hit_idx (w_hit_idx)
    );

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (w_accept && w_miss_ok) w_next = WALK;
            WALK:    if (walk_done) w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NENTRY; i++) r_tlb[i] <= '0;
            r_ptr        <= '0;
            r_va         <= '0;
            r_asid       <= '0;
            r_flush_seen <= 1'b0;
            r_resp_valid <= 1'b0;
            r_resp_pa    <= '0;
            r_resp_fault <= 1'b0;
        end else begin
            r_resp_valid <= 1'b0;
            if (w_accept) begin
                r_va   <= req_va;
                r_asid <= w_asid;
                unique case (1'b1)
                    w_bare: begin
                        r_resp_valid <= 1'b1;
                        r_resp_pa    <= req_va;
                        r_resp_fault <= 1'b0;
                    end
                    w_bad: begin
                        r_resp_valid <= 1'b1;
                        r_resp_pa    <= '0;
                        r_resp_fault <= 1'b1;
                    end
                    w_hit_ok: begin
                        r_resp_valid <= 1'b1;
                        r_resp_pa    <= {8'b0, r_tlb[w_hit_idx].ppn,
                                         req_va[11:0]};
                        r_resp_fault <= 1'b0;
                    end
                    w_miss_ok: ;
                    default: ;
                endcase
            end
            if (w_walk_end) begin
                r_resp_valid <= 1'b1;
                r_resp_pa    <= walk_ok ? walk_pa : '0;
                r_resp_fault <= !walk_ok;
            end
            if (r_state == WALK && !walk_done) begin
                if (flush) r_flush_seen <= 1'b1;
            end else begin
                r_flush_seen <= 1'b0;
            end
            if (w_install) begin
                r_tlb[r_ptr] <= '{valid: 1'b1,
                                  asid:  TLB_ASID_W'(r_asid),
                                  vpn:   r_va[38:12],
                                  ppn:   walk_pa[55:12]};
                r_ptr <= r_ptr + 1'b1;
            end
            if (flush) begin
                for (int i = 0; i < NENTRY; i++) r_tlb[i].valid <= 1'b0;
            end
        end
    end

`ifdef TLB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else if (w_accept) begin
            if (w_hit_ok)  hit_cnt  <= hit_cnt + 32'd1;
            if (w_miss_ok) miss_cnt <= miss_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_tlb_sv39.sv
// Directed testbench for tlb_sv39 (default build, stats disabled).
module tb_tlb_sv39;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] req_va;
    logic [63:0] satp;
    logic        flush;
    logic        resp_valid;
    logic [63:0] resp_pa;
    logic        resp_fault;
    logic        walk_req;
    logic [63:0] walk_va;
    logic        walk_done;
    logic        walk_ok;
    logic [63:0] walk_pa;

    int checks   = 0;
    int failures = 0;

    localparam logic [63:0] SATP0 = 64'h8000_0000_0008_0000;
    localparam logic [63:0] SATP1 = 64'h8000_1000_0008_0000;

    always #5 clk = ~clk;

    tlb_sv39 #(.NENTRY(8), .ASID_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_va     (req_va),
        .satp       (satp),
        .flush      (flush),
        .resp_valid (resp_valid),
        .resp_pa    (resp_pa),
        .resp_fault (resp_fault),
        .walk_req   (walk_req),
        .walk_va    (walk_va),
        .walk_done  (walk_done),
        .walk_ok    (walk_ok),
        .walk_pa    (walk_pa)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for req_ready, then present one request for one edge.
    task automatic send(input logic [63:0] va, input logic [63:0] sp);
        int n = 0;
        while (!req_ready && n < 20) begin
            tick();
            n++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL send_timeout req_ready=%0b exp=1", req_ready);
        end
        req_va    = va;
        satp      = sp;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    // Walker model: answer after n cycles with a one-cycle walk_done.
    task automatic walker(input int n, input logic ok, input logic [63:0] pa);
        repeat (n) tick();
        walk_done = 1'b1;
        walk_ok   = ok;
        walk_pa   = pa;
        tick();
        walk_done = 1'b0;
        walk_ok   = 1'b0;
        walk_pa   = '0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_ready got=%0b exp=0", req_ready);
        end
        checks++;
        if ({resp_valid, resp_fault, walk_req} !== 3'b000) begin
            failures++;
            $display("FAIL rst_flags got=%b exp=000",
                     {resp_valid, resp_fault, walk_req});
        end
        checks++;
        if (resp_pa !== 64'h0 || walk_va !== 64'h0) begin
            failures++;
            $display("FAIL rst_data pa=%h va=%h exp=0", resp_pa, walk_va);
        end
        reset = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_ready_after got=%0b exp=1", req_ready);
        end
    endtask

    task automatic test_bare();
        send(64'h8000_1234, 64'h0);
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b0 ||
            resp_pa !== 64'h8000_1234) begin
            failures++;
            $display("FAIL bare_resp v=%0b f=%0b pa=%h exp 1/0/80001234",
                     resp_valid, resp_fault, resp_pa);
        end
        checks++;
        if (walk_req !== 1'b0) begin
            failures++;
            $display("FAIL bare_walk got=%0b exp=0", walk_req);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || walk_req !== 1'b0) begin
            failures++;
            $display("FAIL bare_pulse v=%0b w=%0b exp=0/0",
                     resp_valid, walk_req);
        end
    endtask

    task automatic test_miss_hit();
        send(64'h4000_5678, SATP0);
        checks++;
        if (walk_req !== 1'b1 || walk_va !== 64'h4000_5678 ||
            resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL miss_walk w=%0b va=%h v=%0b exp 1/40005678/0",
                     walk_req, walk_va, resp_valid);
        end
        walker(5, 1'b1, 64'h8765_4678);
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b0 ||
            resp_pa !== 64'h8765_4678) begin
            failures++;
            $display("FAIL miss_resp v=%0b f=%0b pa=%h exp 1/0/87654678",
                     resp_valid, resp_fault, resp_pa);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL miss_pulse got=%0b exp=0", resp_valid);
        end
        send(64'h4000_5abc, SATP0);
        checks++;
        if (resp_valid !== 1'b1 || resp_pa !== 64'h8765_4abc ||
            walk_req !== 1'b0) begin
            failures++;
            $display("FAIL hit_resp v=%0b pa=%h w=%0b exp 1/87654abc/0",
                     resp_valid, resp_pa, walk_req);
        end
    endtask

    task automatic test_asid();
        send(64'h4000_5678, SATP1);
        checks++;
        if (walk_req !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL asid_miss w=%0b v=%0b exp=1/0",
                     walk_req, resp_valid);
        end
        walker(2, 1'b1, 64'h1111_2678);
        checks++;
        if (resp_valid !== 1'b1 || resp_pa !== 64'h1111_2678) begin
            failures++;
            $display("FAIL asid_resp v=%0b pa=%h exp 1/11112678",
                     resp_valid, resp_pa);
        end
    endtask

    task automatic test_fault();
        send(64'h0000_3000, SATP0);
        walker(1, 1'b0, 64'hdead_b000);
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b1 ||
            resp_pa !== 64'h0) begin
            failures++;
            $display("FAIL walk_fault v=%0b f=%0b pa=%h exp 1/1/0",
                     resp_valid, resp_fault, resp_pa);
        end
        send(64'h0000_3000, SATP0);
        checks++;
        if (walk_req !== 1'b1) begin
            failures++;
            $display("FAIL fault_recache got=%0b exp=1", walk_req);
        end
        walker(1, 1'b0, 64'h0);
        send(64'h0000_0080_0000_0000, SATP0);
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b1 ||
            resp_pa !== 64'h0 || walk_req !== 1'b0) begin
            failures++;
            $display("FAIL noncanon v=%0b f=%0b pa=%h w=%0b exp 1/1/0/0",
                     resp_valid, resp_fault, resp_pa, walk_req);
        end
        send(64'h4000_5678, 64'h9000_0000_0000_0000);
        checks++;
        if (resp_valid !== 1'b1 || resp_fault !== 1'b1 ||
            walk_req !== 1'b0) begin
            failures++;
            $display("FAIL bad_mode v=%0b f=%0b w=%0b exp 1/1/0",
                     resp_valid, resp_fault, walk_req);
        end
    endtask

    task automatic test_flush();
        send(64'h0000_7000, SATP0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        walker(3, 1'b1, 64'h2222_2000);
        checks++;
        if (resp_valid !== 1'b1 || resp_pa !== 64'h2222_2000 ||
            resp_fault !== 1'b0) begin
            failures++;
            $display("FAIL flush_resp v=%0b pa=%h f=%0b exp 1/22222000/0",
                     resp_valid, resp_pa, resp_fault);
        end
        tick();
        walk_done = 1'b1;
        walk_ok   = 1'b1;
        tick();
        walk_done = 1'b0;
        walk_ok   = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || walk_req !== 1'b0) begin
            failures++;
            $display("FAIL stray_done v=%0b w=%0b exp 0/0",
                     resp_valid, walk_req);
        end
        flush = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            failures++;
            $display("FAIL flush_ready got=%0b exp=0", req_ready);
        end
        tick();
        flush = 1'b0;
        send(64'h4000_5abc, SATP0);
        checks++;
        if (walk_req !== 1'b1) begin
            failures++;
            $display("FAIL flush_clears got=%0b exp=1", walk_req);
        end
        walker(1, 1'b1, 64'h8765_4abc);
        send(64'h0000_7000, SATP0);
        checks++;
        if (walk_req !== 1'b1) begin
            failures++;
            $display("FAIL flush_noinstall got=%0b exp=1", walk_req);
        end
        walker(1, 1'b1, 64'h2222_2000);
    endtask

    task automatic test_wrap();
        logic [63:0] va;
        flush = 1'b1;
        tick();
        flush = 1'b0;
        for (int k = 0; k < 9; k++) begin
            va = 64'((32'h100 + k) << 12) | 64'h010;
            send(va, SATP0);
            checks++;
            if (walk_req !== 1'b1) begin
                failures++;
                $display("FAIL wrap_fill%0d got=%0b exp=1", k, walk_req);
            end
            walker(1, 1'b1, 64'h00AB_0000_0000 | 64'(k << 12));
        end
        send(64'h0010_1010, SATP0);
        checks++;
        if (resp_valid !== 1'b1 || walk_req !== 1'b0 ||
            resp_pa !== 64'h00AB_0000_1010) begin
            failures++;
            $display("FAIL wrap_keep v=%0b w=%0b pa=%h exp 1/0/ab00001010",
                     resp_valid, walk_req, resp_pa);
        end
        send(64'h0010_0010, SATP0);
        checks++;
        if (walk_req !== 1'b1 || resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL wrap_evict w=%0b v=%0b exp 1/0",
                     walk_req, resp_valid);
        end
        walker(1, 1'b1, 64'h00AB_0000_0000);
    endtask

    task automatic test_reset_midwalk();
        send(64'h0009_0000, SATP0);
        checks++;
        if (walk_req !== 1'b1) begin
            failures++;
            $display("FAIL mid_walk got=%0b exp=1", walk_req);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (walk_req !== 1'b0 || walk_va !== 64'h0) begin
            failures++;
            $display("FAIL mid_abort w=%0b va=%h exp 0/0", walk_req, walk_va);
        end
        reset = 1'b0;
        walker(0, 1'b1, 64'h3333_3000);
        checks++;
        if (resp_valid !== 1'b0) begin
            failures++;
            $display("FAIL mid_noresp got=%0b exp=0", resp_valid);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            failures++;
            $display("FAIL mid_idle v=%0b r=%0b exp 0/1",
                     resp_valid, req_ready);
        end
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = 1'b0;
        req_va    = '0;
        satp      = '0;
        flush     = 1'b0;
        walk_done = 1'b0;
        walk_ok   = 1'b0;
        walk_pa   = '0;
        test_reset();
        test_bare();
        test_miss_hit();
        test_asid();
        test_fault();
        test_flush();
        test_wrap();
        test_reset_midwalk();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
